// File: rtl/rv_iommu_ds_rd_arb.sv
// rv_iommu_ds_rd_arb: round-robin arbiter sharing the IOMMU data-structure
// read port (AR/R) among N_REQ walkers, one burst outstanding at a time.
// Optional build macro RV_IOMMU_DS_ARB_PRIO0_EN gives requester 0 (CQ/FQ)
// absolute priority; round-robin then continues among the other requesters.
module rv_iommu_ds_rd_arb #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ*8-1:0]          req_len_i,
  output logic [N_REQ-1:0]            rsp_valid_o,
  input  logic [N_REQ-1:0]            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]       rsp_data_o,
  output logic                        rsp_last_o,
  output logic                        rsp_err_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  output logic [ADDR_WIDTH-1:0]       ar_addr_o,
  output logic [7:0]                  ar_len_o,
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  input  logic [DATA_WIDTH-1:0]       r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_last_i,
  output logic                        busy_o
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       rr_ptr_n;
  logic [PTR_W-1:0]       gnt_idx;
  logic [PTR_W-1:0]       winner;
  logic                   found;
  logic [PTR_W:0]         scan_sum;
  logic [PTR_W-1:0]       scan_idx;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [7:0]             len_q;
  logic                   last_fire;

  assign busy_o    = (state != IDLE);
  assign last_fire = (state == R) && r_valid_i && rsp_ready_i[gnt_idx] && r_last_i;

  // Pick the first requesting walker starting at rr_ptr, wrapping at N_REQ.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
`ifdef RV_IOMMU_DS_ARB_PRIO0_EN
    if (req_valid_i[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!found && req_valid_i[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Next round-robin pointer once the current burst's last beat is taken.
  always_comb begin
    if (gnt_idx == PTR_W'(N_REQ - 1)) begin
      rr_ptr_n = '0;
    end else begin
      rr_ptr_n = gnt_idx + 1'b1;
    end
`ifdef RV_IOMMU_DS_ARB_PRIO0_EN
    if (gnt_idx == '0) begin
      rr_ptr_n = rr_ptr;
    end
`endif
  end

  // Next-state logic and all handshake/steering outputs.
  always_comb begin
    state_n     = state;
    req_ready_o = '0;
    ar_valid_o  = 1'b0;
    ar_addr_o   = '0;
    ar_len_o    = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    rsp_last_o  = 1'b0;
    rsp_err_o   = 1'b0;
    r_ready_o   = 1'b0;
    case (state)
      IDLE: begin
        if (found && !rst_i) begin
          req_ready_o[winner] = 1'b1;
          state_n             = AR;
        end
      end
      AR: begin
        ar_valid_o = 1'b1;
        ar_addr_o  = addr_q;
        ar_len_o   = len_q;
        if (ar_ready_i) begin
          state_n = R;
        end
      end
      R: begin
        rsp_valid_o[gnt_idx] = r_valid_i;
        r_ready_o            = rsp_ready_i[gnt_idx];
        rsp_data_o           = r_data_i;
        rsp_last_o           = r_last_i;
        rsp_err_o            = (r_resp_i != 2'b00);
        if (last_fire) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register, grant capture and round-robin pointer update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_idx <= '0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        gnt_idx <= winner;
        addr_q  <= req_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
        len_q   <= req_len_i[winner*8 +: 8];
      end
      if (last_fire) begin
        rr_ptr <= rr_ptr_n;
      end
    end
  end

endmodule

// File: tb/tb_rv_iommu_ds_rd_arb.sv
// Directed testbench for rv_iommu_ds_rd_arb (N_REQ=4, 64-bit address/data).
// Expected grant orders for the priority scenario follow RV_IOMMU_DS_ARB_PRIO0_EN.
module tb_rv_iommu_ds_rd_arb;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_len;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic            rsp_err;
  logic            ar_valid;
  logic            ar_ready;
  logic [AW-1:0]   ar_addr;
  logic [7:0]      ar_len;
  logic            r_valid;
  logic            r_ready;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_resp;
  logic            r_last;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;

  rv_iommu_ds_rd_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_last_o(rsp_last), .rsp_err_o(rsp_err),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
    .ar_addr_o(ar_addr), .ar_len_o(ar_len),
    .r_valid_i(r_valid), .r_ready_o(r_ready),
    .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last),
    .busy_o(busy)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task clear_inputs;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    rsp_ready = '0;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_data    = '0;
    r_resp    = 2'b00;
    r_last    = 1'b0;
  endtask

  task do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single-beat burst from one requester, used only to position rr_ptr.
  task run_quiet_burst(input int idx);
    req_valid = 4'(1 << idx);
    req_len[idx*8 +: 8] = 8'd0;
    tick();
    req_valid = '0;
    ar_ready  = 1'b1;
    tick();
    ar_ready  = 1'b0;
    r_valid   = 1'b1;
    r_last    = 1'b1;
    rsp_ready = '1;
    tick();
    r_valid   = 1'b0;
    r_last    = 1'b0;
    rsp_ready = '0;
  endtask

  task test_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
    compared++; if (ar_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ar_valid: got %0h expected 0", ar_valid); end
    compared++; if (ar_addr !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_ar_addr: got %0h expected 0", ar_addr); end
    compared++; if (ar_len !== 8'h0) begin mismatched++; $display("[TB] FAIL reset_ar_len: got %0h expected 0", ar_len); end
    compared++; if (req_ready !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_req_ready: got %0h expected 0", req_ready); end
    rst       = 1'b0;
    r_valid   = 1'b1;
    r_data    = 64'hFFFF_0000_FFFF_0000;
    r_last    = 1'b1;
    rsp_ready = '1;
    #1;
    compared++; if (r_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_r_ready: got %0h expected 0", r_ready); end
    compared++; if (rsp_valid !== 4'h0) begin mismatched++; $display("[TB] FAIL idle_rsp_valid: got %0h expected 0", rsp_valid); end
    compared++; if (rsp_data !== 64'h0) begin mismatched++; $display("[TB] FAIL idle_rsp_data: got %0h expected 0", rsp_data); end
    tick();
    clear_inputs();
  endtask

  task test_single_request;
    do_reset();
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 64'h8000_1000;
    req_len[2*8 +: 8]    = 8'd3;
    #1;
    compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("[TB] FAIL single_req_ready: got %0h expected 4", req_ready); end
    compared++; if (ar_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_ar_early: got %0h expected 0", ar_valid); end
    tick();
    req_valid = '0;
    ar_ready  = 1'b1;
    #1;
    compared++; if (ar_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_ar_valid: got %0h expected 1", ar_valid); end
    compared++; if (ar_addr !== 64'h8000_1000) begin mismatched++; $display("[TB] FAIL single_ar_addr: got %0h expected 80001000", ar_addr); end
    compared++; if (ar_len !== 8'd3) begin mismatched++; $display("[TB] FAIL single_ar_len: got %0h expected 3", ar_len); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_busy: got %0h expected 1", busy); end
    tick();
    ar_ready  = 1'b0;
    rsp_ready = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      r_valid = 1'b1;
      r_data  = 64'hA5A5_0000_0000_0000 + 64'(b);
      r_last  = (b == 3);
      #1;
      if (b == 0) begin
        compared++; if (ar_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_ar_one_cycle: got %0h expected 0", ar_valid); end
      end
      compared++; if (rsp_valid !== 4'b0100) begin mismatched++; $display("[TB] FAIL single_rsp_valid beat %0d: got %0h expected 4", b, rsp_valid); end
      compared++; if (rsp_data !== 64'hA5A5_0000_0000_0000 + 64'(b)) begin mismatched++; $display("[TB] FAIL single_rsp_data beat %0d: got %0h", b, rsp_data); end
      compared++; if (rsp_last !== (b == 3)) begin mismatched++; $display("[TB] FAIL single_rsp_last beat %0d: got %0h expected %0h", b, rsp_last, (b == 3)); end
      compared++; if (r_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL single_r_ready beat %0d: got %0h expected 1", b, r_ready); end
      tick();
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_busy_drop: got %0h expected 0", busy); end
    tick();
    clear_inputs();
  endtask

  task test_fairness;
    int exp_order[6];
    int e;
    exp_order = '{0, 1, 2, 3, 0, 1};
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = 64'(i * 256 + 64);
    end
    rsp_ready = '1;
    for (int n = 0; n < 6; n++) begin
      e = exp_order[n];
      #1;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL fair_idle burst %0d: got busy %0h expected 0", n, busy); end
      compared++; if (req_ready !== 4'(1 << e)) begin mismatched++; $display("[TB] FAIL fair_grant burst %0d: got %0h expected %0h", n, req_ready, 4'(1 << e)); end
      tick();
      ar_ready = 1'b1;
      #1;
      compared++; if (ar_addr !== 64'(e * 256 + 64)) begin mismatched++; $display("[TB] FAIL fair_ar_addr burst %0d: got %0h expected %0h", n, ar_addr, 64'(e * 256 + 64)); end
      tick();
      ar_ready = 1'b0;
      r_valid  = 1'b1;
      r_last   = 1'b1;
      #1;
      compared++; if (rsp_valid !== 4'(1 << e)) begin mismatched++; $display("[TB] FAIL fair_rsp_valid burst %0d: got %0h expected %0h", n, rsp_valid, 4'(1 << e)); end
      tick();
      r_valid = 1'b0;
      r_last  = 1'b0;
    end
    clear_inputs();
    tick();
  endtask

  task test_backpressure;
    logic rdy_pat [6];
    int   beat;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    beat = 0;
    do_reset();
    req_valid = 4'b0010;
    req_addr[1*AW +: AW] = 64'h1234_5678_9ABC_DEF0;
    req_len[1*8 +: 8]    = 8'd2;
    #1;
    compared++; if (req_ready !== 4'b0010) begin mismatched++; $display("[TB] FAIL bp_req_ready: got %0h expected 2", req_ready); end
    tick();
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      compared++; if (ar_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ar_valid stall %0d: got %0h expected 1", c, ar_valid); end
      compared++; if (ar_addr !== 64'h1234_5678_9ABC_DEF0) begin mismatched++; $display("[TB] FAIL bp_ar_addr stall %0d: got %0h", c, ar_addr); end
      compared++; if (ar_len !== 8'd2) begin mismatched++; $display("[TB] FAIL bp_ar_len stall %0d: got %0h expected 2", c, ar_len); end
      tick();
    end
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      rsp_ready = {1'b1, 1'b0, rdy_pat[c], 1'b0};
      r_valid   = 1'b1;
      r_data    = 64'hD000 + 64'(beat);
      r_last    = (beat == 2);
      #1;
      compared++; if (r_ready !== rdy_pat[c]) begin mismatched++; $display("[TB] FAIL bp_r_ready cycle %0d: got %0h expected %0h", c, r_ready, rdy_pat[c]); end
      compared++; if (rsp_valid !== 4'b0010) begin mismatched++; $display("[TB] FAIL bp_rsp_valid cycle %0d: got %0h expected 2", c, rsp_valid); end
      if (r_ready && r_valid) begin
        compared++; if (rsp_data !== 64'hD000 + 64'(beat)) begin mismatched++; $display("[TB] FAIL bp_rsp_data beat %0d: got %0h", beat, rsp_data); end
        beat++;
      end
      tick();
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    #1;
    compared++; if (beat !== 3) begin mismatched++; $display("[TB] FAIL bp_beat_count: got %0d expected 3", beat); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_busy_end: got %0h expected 0", busy); end
    tick();
    clear_inputs();
  endtask

  task test_error_beat;
    do_reset();
    req_valid = 4'b1000;
    req_addr[3*AW +: AW] = 64'h3000;
    req_len[3*8 +: 8]    = 8'd3;
    tick();
    req_valid = '0;
    ar_ready  = 1'b1;
    tick();
    ar_ready  = 1'b0;
    rsp_ready = 4'b1000;
    for (int b = 0; b < 4; b++) begin
      r_valid = 1'b1;
      r_resp  = (b == 1) ? 2'b10 : 2'b00;
      r_last  = (b == 3);
      #1;
      compared++; if (rsp_err !== (b == 1)) begin mismatched++; $display("[TB] FAIL err_flag beat %0d: got %0h expected %0h", b, rsp_err, (b == 1)); end
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL err_busy beat %0d: got %0h expected 1", b, busy); end
      compared++; if (rsp_valid !== 4'b1000) begin mismatched++; $display("[TB] FAIL err_rsp_valid beat %0d: got %0h expected 8", b, rsp_valid); end
      tick();
    end
    r_valid = 1'b0;
    r_resp  = 2'b00;
    r_last  = 1'b0;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL err_busy_end: got %0h expected 0", busy); end
    tick();
    clear_inputs();
  endtask

  task test_reset_mid_burst;
    do_reset();
    run_quiet_burst(1);
    req_valid = 4'b0100;
    req_len[2*8 +: 8] = 8'd7;
    tick();
    req_valid = '0;
    ar_ready  = 1'b1;
    tick();
    ar_ready  = 1'b0;
    rsp_ready = 4'b0100;
    r_valid   = 1'b1;
    r_last    = 1'b0;
    #1;
    compared++; if (r_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_mid_beat1: got %0h expected 1", r_ready); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_busy: got %0h expected 0", busy); end
    compared++; if (r_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_r_ready: got %0h expected 0", r_ready); end
    compared++; if (rsp_valid !== 4'h0) begin mismatched++; $display("[TB] FAIL rst_mid_rsp_valid: got %0h expected 0", rsp_valid); end
    r_valid   = 1'b0;
    req_valid = 4'b1010;
    req_addr[1*AW +: AW] = 64'h1111_0000;
    req_len = '0;
    #1;
    compared++; if (req_ready !== 4'b0010) begin mismatched++; $display("[TB] FAIL rst_mid_regrant: got %0h expected 2", req_ready); end
    tick();
    req_valid = '0;
    ar_ready  = 1'b1;
    #1;
    compared++; if (ar_addr !== 64'h1111_0000) begin mismatched++; $display("[TB] FAIL rst_mid_ar_addr: got %0h expected 11110000", ar_addr); end
    tick();
    ar_ready  = 1'b0;
    rsp_ready = '1;
    r_valid   = 1'b1;
    r_last    = 1'b1;
    #1;
    compared++; if (rsp_valid !== 4'b0010) begin mismatched++; $display("[TB] FAIL rst_mid_rsp_valid2: got %0h expected 2", rsp_valid); end
    tick();
    clear_inputs();
    tick();
  endtask

  task test_priority;
    int exp_order[2];
    int e;
`ifdef RV_IOMMU_DS_ARB_PRIO0_EN
    exp_order = '{0, 3};
`else
    exp_order = '{3, 0};
`endif
    do_reset();
    run_quiet_burst(2);
    req_valid = 4'b1011;
    for (int n = 0; n < 2; n++) begin
      e = exp_order[n];
      #1;
      compared++; if (req_ready !== 4'(1 << e)) begin mismatched++; $display("[TB] FAIL prio_grant burst %0d: got %0h expected %0h", n, req_ready, 4'(1 << e)); end
      tick();
      ar_ready = 1'b1;
      tick();
      ar_ready  = 1'b0;
      r_valid   = 1'b1;
      r_last    = 1'b1;
      rsp_ready = '1;
      #1;
      compared++; if (rsp_valid !== 4'(1 << e)) begin mismatched++; $display("[TB] FAIL prio_rsp_valid burst %0d: got %0h expected %0h", n, rsp_valid, 4'(1 << e)); end
      tick();
      r_valid = 1'b0;
      r_last  = 1'b0;
    end
    clear_inputs();
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_request();
    test_fairness();
    test_backpressure();
    test_error_beat();
    test_reset_mid_burst();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
